// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit common-anode 7-segment driver: hex decode, dot/blank masks,
// frame-synchronous double buffering and PWM dimming. Optional macro SEG_LZ_BLANK_EN adds leading-zero blanking.
module seg_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 125000,
  parameter int BRIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dot_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     seg_an,
  output logic [7:0]            seg_seg,
  output logic                  frame_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic                tick, last_digit, boundary;

  logic [4*DIGITS-1:0] stg_data, disp_data;
  logic [DIGITS-1:0]   stg_dot, disp_dot, stg_blank, disp_blank;
  logic                pending;

  logic [DIGITS-1:0]   an_p1;
  logic [7:0]          seg_p1;
  logic                frame_p1;

  assign tick       = (cnt == CNT_W'(TICK_DIV - 1));
  assign last_digit = (idx == IDX_W'(DIGITS - 1));
  assign boundary   = tick && last_digit;

  // Stage 0: prescaler, scan index and PWM phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      pwm_cnt  <= '0;
      frame_p1 <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + 1'b1;
      pwm_cnt  <= tick ? '0 : pwm_cnt + 1'b1;
      frame_p1 <= boundary;
      if (tick) idx <= last_digit ? '0 : idx + 1'b1;
    end
  end

  // A load landing exactly on the boundary bypasses staging so it shows in the very next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data   <= '0;
      stg_dot    <= '0;
      stg_blank  <= '1;
      disp_data  <= '0;
      disp_dot   <= '0;
      disp_blank <= '1;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        stg_data  <= data_in;
        stg_dot   <= dot_in;
        stg_blank <= blank_in;
      end
      if (boundary && load) begin
        disp_data  <= data_in;
        disp_dot   <= dot_in;
        disp_blank <= blank_in;
        pending    <= 1'b0;
      end else if (boundary && pending) begin
        disp_data  <= stg_data;
        disp_dot   <= stg_dot;
        disp_blank <= stg_blank;
        pending    <= 1'b0;
      end else if (load) begin
        pending    <= 1'b1;
      end
    end
  end

  logic [DIGITS-1:0] lz_mask;
`ifdef SEG_LZ_BLANK_EN
  logic lz_run;
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lz_run && disp_data[4*k +: 4] == 4'h0 && !disp_dot[k]) lz_mask[k] = 1'b1;
      else lz_run = 1'b0;
    end
  end
`else
  assign lz_mask = '0;
`endif

  logic [3:0]        cur_nib;
  logic              cur_dot, cur_dark, pwm_on;
  logic [DIGITS-1:0] an_nx;
  logic [7:0]        seg_nx;

  always_comb begin
    cur_nib  = 4'h0;
    cur_dot  = 1'b0;
    cur_dark = 1'b1;
    pwm_on   = (pwm_cnt <= bright);
    an_nx    = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (IDX_W'(k) == idx) begin
        cur_nib  = disp_data[4*k +: 4];
        cur_dot  = disp_dot[k];
        cur_dark = disp_blank[k] | lz_mask[k];
        an_nx[k] = !pwm_on;
      end
    end
    if (!pwm_on || cur_dark) seg_nx = 8'hFF;
    else                     seg_nx = {~cur_dot, seg_decode(cur_nib)};
  end

  // Stage 1: registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= '1;
      seg_p1 <= 8'hFF;
    end else begin
      an_p1  <= an_nx;
      seg_p1 <= seg_nx;
    end
  end

  assign seg_an     = an_p1;
  assign seg_seg    = seg_p1;
  assign frame_tick = frame_p1;

endmodule
